// File: rtl/psum_thresh_accum.sv
// Pipelined LANES-wide psum adder tree with multi-pass accumulation, per-channel bias FIFO,
// and binarised activation output. Feeds the ofmap BRAM write port.
module psum_thresh_accum #(
  parameter int LANES      = 256,
  parameter int IN_W       = 6,
  parameter int ADDR_W     = 12,
  parameter int PASS_W     = 8,
  parameter int BIAS_W     = 16,
  parameter int BIAS_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PASS_W-1:0]                     cfg_passes,
  input  logic                                  cfg_strict,
  input  logic [LANES*IN_W-1:0]                 psum_in,
  input  logic [ADDR_W-1:0]                     address_in,
  input  logic                                  i_valid,
  input  logic                                  layer_finish,
  input  logic [BIAS_W-1:0]                     bias_in,
  input  logic                                  bias_valid,
  output logic                                  bias_ready,
  output logic                                  o_data,
  output logic [IN_W+$clog2(LANES)+PASS_W:0]    o_sum,
  output logic [ADDR_W-1:0]                     address_out,
  output logic                                  o_valid,
  output logic                                  o_last,
  output logic                                  bias_overflow,
  output logic                                  bias_underflow
);

  localparam int L      = $clog2(LANES);
  localparam int TREE_W = IN_W + L;
  localparam int ACC_W  = IN_W + L + PASS_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam int PTR_W  = $clog2(BIAS_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // ---------------- input stage and side pipelines ----------------
  logic [LANES*IN_W-1:0] lane_d, lane_q;
  logic [ADDR_W-1:0]     addr_d [L+1];
  logic [ADDR_W-1:0]     addr_q [L+1];
  logic [L:0]            vld_d, vld_q;
  logic [L+2:0]          lf_d, lf_q;

  always_comb begin
    lane_d    = i_valid ? psum_in : lane_q;
    addr_d[0] = i_valid ? address_in : addr_q[0];
    for (int s = 1; s <= L; s++) begin
      addr_d[s] = addr_q[s-1];
    end
    vld_d = {vld_q[L-1:0], i_valid};
    lf_d  = {lf_q[L+1:0], layer_finish};
  end

  always_ff @(posedge clk) begin
    lane_q <= lane_d;
    addr_q <= addr_d;
  end

  // ---------------- adder tree: level s holds LANES>>s sums of IN_W+s bits ----------------
  for (genvar s = 1; s <= L; s++) begin : g_lvl
    localparam int N = LANES >> s;
    localparam int W = IN_W + s;
    logic [2*N*(W-1)-1:0] src;
    logic [N*W-1:0]       sum_d, sum_q;

    if (s == 1) begin : g_src_lane
      assign src = lane_q;
    end else begin : g_src_prev
      assign src = g_lvl[s-1].sum_q;
    end

    always_comb begin
      sum_d = '0;
      for (int k = 0; k < N; k++) begin
        sum_d[k*W +: W] = {src[2*k*(W-1) + W-2], src[2*k*(W-1) +: W-1]}
                        + {src[(2*k+1)*(W-1) + W-2], src[(2*k+1)*(W-1) +: W-1]};
      end
    end

    always_ff @(posedge clk) begin
      sum_q <= sum_d;
    end
  end

  logic [TREE_W-1:0] tree_sum;
  assign tree_sum = g_lvl[L].sum_q;

  // ---------------- accumulate stage ----------------
  logic [PASS_W-1:0] pcnt_d, pcnt_q, p_last;
  logic [ACC_W-1:0]  acc_d, acc_q, tree_ext;
  logic              fin_d, fin_q;
  logic [ADDR_W-1:0] fin_addr_d, fin_addr_q;

  always_comb begin
    p_last     = (cfg_passes == '0) ? '0 : cfg_passes - PASS_W'(1);
    tree_ext   = {{PASS_W{tree_sum[TREE_W-1]}}, tree_sum};
    pcnt_d     = pcnt_q;
    acc_d      = acc_q;
    fin_d      = 1'b0;
    fin_addr_d = fin_addr_q;
    if (vld_q[L]) begin
      acc_d = (pcnt_q == '0) ? tree_ext : acc_q + tree_ext;
      if (pcnt_q == p_last) begin
        fin_d      = 1'b1;
        fin_addr_d = addr_q[L];
        pcnt_d     = '0;
      end else begin
        pcnt_d = pcnt_q + PASS_W'(1);
      end
    end
    // end of layer drops any partially accumulated output
    if (lf_q[L]) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    fin_addr_q <= fin_addr_d;
  end

  // ---------------- bias FIFO and output stage ----------------
  logic [BIAS_W-1:0] bias_mem_q [BIAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              full, empty, push, pop;
  logic [BIAS_W-1:0] bias_sel;
  logic [SUM_W-1:0]  sum_calc;
  logic              ovf_d, ovf_q, unf_d, unf_q;
  logic [SUM_W-1:0]  o_sum_d, o_sum_q;
  logic              o_data_d, o_data_q, o_valid_d, o_valid_q;
  logic [ADDR_W-1:0] o_addr_d, o_addr_q;

  always_comb begin
    full     = (cnt_q == CNT_W'(BIAS_DEPTH));
    empty    = (cnt_q == '0);
    push     = bias_valid && !full;
    pop      = fin_q && !empty;
    bias_sel = pop ? bias_mem_q[rd_ptr_q] : '0;
    sum_calc = {acc_q[ACC_W-1], acc_q}
             + {{(SUM_W-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel};

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    ovf_d = (lf_q[L] ? 1'b0 : ovf_q) | (bias_valid && full);
    unf_d = (lf_q[L] ? 1'b0 : unf_q) | (fin_q && empty);

    o_sum_d   = o_sum_q;
    o_data_d  = o_data_q;
    o_addr_d  = o_addr_q;
    o_valid_d = fin_q;
    if (fin_q) begin
      o_sum_d  = sum_calc;
      o_data_d = cfg_strict ? (!sum_calc[SUM_W-1] && (|sum_calc)) : !sum_calc[SUM_W-1];
      o_addr_d = fin_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      bias_mem_q[wr_ptr_q] <= bias_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      lf_q      <= '0;
      pcnt_q    <= '0;
      acc_q     <= '0;
      fin_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      o_sum_q   <= '0;
      o_data_q  <= 1'b0;
      o_addr_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      lf_q      <= lf_d;
      pcnt_q    <= pcnt_d;
      acc_q     <= acc_d;
      fin_q     <= fin_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      o_sum_q   <= o_sum_d;
      o_data_q  <= o_data_d;
      o_addr_q  <= o_addr_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bias_ready     = !full;
  assign o_sum          = o_sum_q;
  assign o_data         = o_data_q;
  assign address_out    = o_addr_q;
  assign o_valid        = o_valid_q;
  assign o_last         = lf_q[L+2];
  assign bias_overflow  = ovf_q;
  assign bias_underflow = unf_q;

endmodule

// File: tb/tb_psum_thresh_accum.sv
// Scoreboard bench for psum_thresh_accum: random beats/biases against a queue-based model.
`timescale 1ns/1ps
module tb_psum_thresh_accum;

  localparam int LANES = 256, IN_W = 6, ADDR_W = 12, PASS_W = 8, BIAS_W = 16, BIAS_DEPTH = 8;
  localparam int L = 8;
  localparam int SUM_W = IN_W + L + PASS_W + 1;
  localparam int LAT = L + 3;
  localparam int RAND = 1000;

  logic                  clk = 1'b0, rst = 1'b1;
  logic [PASS_W-1:0]     cfg_passes = 8'd1;
  logic                  cfg_strict = 1'b0;
  logic [LANES*IN_W-1:0] psum_in = '0;
  logic [ADDR_W-1:0]     address_in = '0;
  logic                  i_valid = 1'b0, layer_finish = 1'b0;
  logic [BIAS_W-1:0]     bias_in = '0;
  logic                  bias_valid = 1'b0;
  logic                  bias_ready, o_data, o_valid, o_last, bias_overflow, bias_underflow;
  logic [SUM_W-1:0]      o_sum;
  logic [ADDR_W-1:0]     address_out;

  psum_thresh_accum #(
    .LANES(LANES), .IN_W(IN_W), .ADDR_W(ADDR_W), .PASS_W(PASS_W),
    .BIAS_W(BIAS_W), .BIAS_DEPTH(BIAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_passes(cfg_passes), .cfg_strict(cfg_strict),
    .psum_in(psum_in), .address_in(address_in), .i_valid(i_valid),
    .layer_finish(layer_finish), .bias_in(bias_in), .bias_valid(bias_valid),
    .bias_ready(bias_ready), .o_data(o_data), .o_sum(o_sum), .address_out(address_out),
    .o_valid(o_valid), .o_last(o_last), .bias_overflow(bias_overflow),
    .bias_underflow(bias_underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint            sum;
    bit                data;
    logic [ADDR_W-1:0] addr;
    int                due;
  } exp_t;

  exp_t   exp_q[$];
  int     last_q[$];
  longint bias_m[$];
  int     pcnt_m = 0;
  longint acc_m = 0;
  bit     ovf_m = 0, unf_m = 0;
  int     checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: compare every presented output with the scoreboard head
  exp_t mon_e;
  int   mon_due;
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk("o_valid_unexpected", o_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("o_sum", $signed(o_sum), mon_e.sum);
        chk("o_data", o_data, mon_e.data);
        chk("address_out", address_out, mon_e.addr);
        chk("o_valid_cycle", cyc, mon_e.due);
      end
    end
    if (o_last) begin
      if (last_q.size() == 0) begin
        chk("o_last_unexpected", o_last, 0);
      end else begin
        mon_due = last_q.pop_front();
        chk("o_last_cycle", cyc, mon_due);
      end
    end
  end

  task automatic clear_inputs();
    i_valid      = 1'b0;
    bias_valid   = 1'b0;
    layer_finish = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic push_bias(input longint val);
    @(negedge clk);
    clear_inputs();
    chk("bias_ready", bias_ready, (bias_m.size() < BIAS_DEPTH) ? 1 : 0);
    bias_in    = BIAS_W'(val);
    bias_valid = 1'b1;
    if (bias_m.size() < BIAS_DEPTH) bias_m.push_back(val);
    else ovf_m = 1'b1;
  endtask

  task automatic push_rand_bias();
    push_bias(longint'(int'($urandom_range(0, 65535)) - 32768));
  endtask

  // fill == RAND gives random lanes, otherwise every lane takes the fill value
  task automatic beat(input logic [ADDR_W-1:0] addr, input int fill);
    logic [LANES*IN_W-1:0] v;
    longint ts, b;
    int     val, p;
    exp_t   e;
    ts = 0;
    for (int k = 0; k < LANES; k++) begin
      val = (fill == RAND) ? int'($urandom_range(0, 63)) - 32 : fill;
      v[k*IN_W +: IN_W] = IN_W'(val);
      ts += val;
    end
    @(negedge clk);
    clear_inputs();
    psum_in    = v;
    address_in = addr;
    i_valid    = 1'b1;
    p = (cfg_passes == 0) ? 1 : int'(cfg_passes);
    if (pcnt_m == 0) acc_m = ts;
    else acc_m += ts;
    if (pcnt_m == p - 1) begin
      if (bias_m.size() > 0) b = bias_m.pop_front();
      else begin
        b = 0;
        unf_m = 1'b1;
      end
      e.sum  = acc_m + b;
      e.data = cfg_strict ? (e.sum > 0) : (e.sum >= 0);
      e.addr = addr;
      e.due  = cyc + LAT;
      exp_q.push_back(e);
      pcnt_m = 0;
    end else begin
      pcnt_m++;
    end
  endtask

  task automatic fin_layer();
    @(negedge clk);
    clear_inputs();
    layer_finish = 1'b1;
    last_q.push_back(cyc + LAT);
    pcnt_m = 0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    pcnt_m = 0;
    bias_m.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  task automatic chk_flags();
    chk("bias_overflow", bias_overflow, ovf_m);
    chk("bias_underflow", bias_underflow, unf_m);
    chk("bias_ready_idle", bias_ready, (bias_m.size() < BIAS_DEPTH) ? 1 : 0);
  endtask

  task automatic chk_reset_state();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_sum", o_sum, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_address_out", address_out, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_bias_overflow", bias_overflow, 0);
    chk("rst_bias_underflow", bias_underflow, 0);
    chk("rst_bias_ready", bias_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nbeat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state();

    // single pass: all +1, bias -255 -> sum 1
    cfg_passes = 8'd1;
    push_bias(-255);
    idle(2);
    beat(12'h05A, 1);
    idle(15);

    // zero sum under both threshold modes
    push_bias(0);
    idle(2);
    beat(12'h100, 0);
    idle(15);
    cfg_strict = 1'b1;
    push_bias(0);
    idle(2);
    beat(12'h101, 0);
    idle(15);
    cfg_strict = 1'b0;

    // three passes of -8192 plus +24576
    cfg_passes = 8'd3;
    push_bias(24576);
    idle(2);
    beat(12'h200, -32);
    beat(12'h201, -32);
    beat(12'h202, -32);
    idle(15);

    // nine pushes into an eight-entry FIFO, then drain in order
    repeat (9) push_rand_bias();
    idle(2);
    chk_flags();
    cfg_passes = 8'd1;
    for (int i = 0; i < 8; i++) beat(ADDR_W'(12'h300 + i), RAND);
    idle(15);
    chk_flags();

    // output with empty FIFO, then end of layer clears the sticky flags
    beat(12'h3F0, RAND);
    idle(15);
    chk_flags();
    fin_layer();
    idle(15);
    chk_flags();

    // reset mid-accumulation discards in-flight beats
    cfg_passes = 8'd4;
    push_rand_bias();
    idle(2);
    beat(12'h400, RAND);
    beat(12'h401, RAND);
    do_reset(1);
    chk_reset_state();
    idle(15);
    push_rand_bias();
    idle(2);
    for (int i = 0; i < 4; i++) beat(ADDR_W'(12'h410 + i), RAND);
    idle(15);
    chk_flags();

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      cfg_passes = PASS_W'($urandom_range(0, 3));
      cfg_strict = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(0, 5));
      for (int i = 0; i < nb; i++) push_rand_bias();
      idle(2);
      nbeat = int'($urandom_range(1, 10));
      for (int i = 0; i < nbeat; i++) begin
        if ($urandom_range(0, 3) == 0) beat(ADDR_W'($urandom), ($urandom_range(0, 1) == 1) ? 31 : -32);
        else beat(ADDR_W'($urandom), RAND);
      end
      idle(15);
      chk_flags();
      fin_layer();
      idle(15);
      chk_flags();
    end

    idle(5);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("last_queue_drained", last_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
